// File: rtl/seven_seg_pkg.sv
// Shared types and active-high glyph constants for the multiplexed 7-segment driver.
// Segment bit order is {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0   = 7'h3F;
  localparam seg_t SEG_1   = 7'h06;
  localparam seg_t SEG_2   = 7'h5B;
  localparam seg_t SEG_3   = 7'h4F;
  localparam seg_t SEG_4   = 7'h66;
  localparam seg_t SEG_5   = 7'h6D;
  localparam seg_t SEG_6   = 7'h7D;
  localparam seg_t SEG_7   = 7'h07;
  localparam seg_t SEG_8   = 7'h7F;
  localparam seg_t SEG_9   = 7'h6F;
  localparam seg_t SEG_A   = 7'h77;
  localparam seg_t SEG_B   = 7'h7C;
  localparam seg_t SEG_C   = 7'h39;
  localparam seg_t SEG_D   = 7'h5E;
  localparam seg_t SEG_E   = 7'h79;
  localparam seg_t SEG_F   = 7'h71;
  localparam seg_t SEG_OFF = 7'h00;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-high segment pattern (hex glyphs 0-9, A, b, C, d, E, F).
module hex_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       glyph
);

  always_comb begin
    glyph = SEG_OFF;
    case (nibble)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_A;
      4'hB: glyph = SEG_B;
      4'hC: glyph = SEG_C;
      4'hD: glyph = SEG_D;
      4'hE: glyph = SEG_E;
      4'hF: glyph = SEG_F;
      default: glyph = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed 7-segment scanner: one digit per slot with a leading blank gap,
// double-buffered value swapped only at the frame boundary, registered pins.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIGIT_CYCLES   = 25000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(DIGIT_CYCLES);
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  localparam logic STATE_BLANK = 1'b0;
  localparam logic STATE_ON    = 1'b1;

  // XOR masks that turn active-high internal levels into pin levels.
  localparam seg_t              SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_POL  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_POL  = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]    cnt_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic                state_reg;
  logic [4*DIGITS-1:0] shadow_val_reg;
  logic [DIGITS-1:0]   shadow_dp_reg;
  logic [4*DIGITS-1:0] disp_val_reg;
  logic [DIGITS-1:0]   disp_dp_reg;
  seg_t                seg_reg;
  logic                dp_reg;
  logic [DIGITS-1:0]   an_reg;
  logic                frame_done_reg;

  logic slot_end;
  logic frame_end;
  assign slot_end  = (state_reg == STATE_ON) && (cnt_reg == CNT_LAST);
  assign frame_end = slot_end && (idx_reg == IDX_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_reg   <= '0;
      idx_reg   <= '0;
      state_reg <= STATE_BLANK;
    end else if (slot_end) begin
      cnt_reg   <= '0;
      state_reg <= STATE_BLANK;
      idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
      if (state_reg == STATE_BLANK && cnt_reg == BLANK_LAST) begin
        state_reg <= STATE_ON;
      end
    end
  end

  // A load landing on the boundary cycle bypasses the shadow so it is not lost for a frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_val_reg <= '0;
      shadow_dp_reg  <= '0;
      disp_val_reg   <= '0;
      disp_dp_reg    <= '0;
    end else begin
      if (load) begin
        shadow_val_reg <= value;
        shadow_dp_reg  <= dp_in;
      end
      if (frame_end) begin
        disp_val_reg <= load ? value : shadow_val_reg;
        disp_dp_reg  <= load ? dp_in : shadow_dp_reg;
      end
    end
  end

  logic [3:0]        nibbles [DIGITS];
  logic [DIGITS-1:0] upper_zero;

  // upper_zero[k]: nibble k and every nibble above it are zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign nibbles[gi]    = disp_val_reg[4*gi +: 4];
    assign upper_zero[gi] = (disp_val_reg[4*DIGITS-1:4*gi] == '0);
  end

  logic [3:0] cur_nibble;
  seg_t       cur_glyph;
  logic       lz_suppress;
  assign cur_nibble  = nibbles[idx_reg];
  assign lz_suppress = lz_blank && (idx_reg != '0) && upper_zero[idx_reg];

  hex_to_7seg u_decode (
    .nibble (cur_nibble),
    .glyph  (cur_glyph)
  );

  seg_t              seg_next;
  logic              dp_next;
  logic [DIGITS-1:0] an_next;

  always_comb begin
    seg_next = SEG_OFF;
    dp_next  = 1'b0;
    an_next  = '0;
    if (state_reg == STATE_ON) begin
      an_next  = DIGITS'(1) << idx_reg;
      dp_next  = disp_dp_reg[idx_reg];
      seg_next = lz_suppress ? SEG_OFF : cur_glyph;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      seg_reg        <= SEG_OFF ^ SEG_POL;
      dp_reg         <= DP_POL;
      an_reg         <= AN_POL;
      frame_done_reg <= 1'b0;
    end else begin
      seg_reg        <= seg_next ^ SEG_POL;
      dp_reg         <= dp_next ^ DP_POL;
      an_reg         <= an_next ^ AN_POL;
      frame_done_reg <= frame_end;
    end
  end

  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign an         = an_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench: stimulus queues the frame contents expected after each boundary,
// the monitor predicts every pin cycle from slot arithmetic and compares.
module tb_seven_seg_scan_driver;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  always #5 CLK = ~CLK;

  seven_seg_scan_driver #(
    .DIGITS         (4),
    .DIGIT_CYCLES   (8),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  int checks = 0;
  int failures = 0;

  // Expected {value, dp} for each upcoming frame.
  logic [19:0] exp_q[$];

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic void check(input string name, input int n, input logic [31:0] actual,
                                input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, n, actual, required);
    end
  endfunction

  // ---------------- stimulus ----------------
  int          k = 0;
  logic [19:0] shadow = '0;
  logic        lz_cur = 1'b0;

  task automatic step(input logic l, input logic [15:0] v, input logic [3:0] d, input logic lz);
    load     = l;
    value    = v;
    dp_in    = d;
    lz_blank = lz;
    if (l) shadow = {v, d};
    if (k % 32 == 31) exp_q.push_back(shadow);
    @(posedge CLK);
    #1;
    k++;
  endtask

  task automatic idle();
    step(1'b0, 16'($urandom), 4'($urandom), lz_cur);
  endtask

  task automatic rand_step();
    logic [15:0] mask;
    case ($urandom_range(0, 4))
      0: mask = 16'hFFFF;
      1: mask = 16'h0FFF;
      2: mask = 16'h00FF;
      3: mask = 16'h000F;
      default: mask = 16'h0000;
    endcase
    if ($urandom_range(0, 19) == 0) lz_cur = ~lz_cur;
    step(($urandom_range(0, 5) == 0), 16'($urandom) & mask, 4'($urandom), lz_cur);
  endtask

  task automatic do_reset(input int cycles);
    RST  = 1'b1;
    load = 1'b0;
    repeat (cycles) begin
      @(posedge CLK);
      #1;
    end
    RST    = 1'b0;
    k      = 0;
    shadow = '0;
  endtask

  initial begin
    do_reset(3);
    while (k < 3) idle();
    step(1'b1, 16'h1234, 4'h0, 1'b0);
    while (k < 45) idle();
    step(1'b1, 16'hABCD, 4'h0, 1'b0);
    while (k < 95) idle();
    step(1'b1, 16'h5A5A, 4'b1010, 1'b0);
    while (k < 100) idle();
    lz_cur = 1'b1;
    step(1'b1, 16'h0050, 4'h0, lz_cur);
    while (k < 140) idle();
    step(1'b1, 16'h0000, 4'h0, lz_cur);
    while (k < 192) idle();
    repeat (320) rand_step();
    while (k % 32 != 20) idle();
    do_reset(1);
    repeat (100) rand_step();
    repeat (40) idle();
    load = 1'b0;
    @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- monitor ----------------
  int          n = 0;
  logic        rst_last = 1'b1;
  logic        lz_last = 1'b0;
  logic [19:0] cur = '0;
  int          m, idx, off;
  logic [15:0] upper;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  always @(negedge CLK) begin
    if (rst_last) begin
      n   = 0;
      cur = '0;
      exp_q.delete();
    end else begin
      n++;
    end
    if (n == 0) begin
      check("reset_an", n, 32'(an), 32'h0F);
      check("reset_seg", n, 32'(seg), 32'h7F);
      check("reset_dp", n, 32'(dp), 32'h1);
      check("reset_frame_done", n, 32'(frame_done), 32'h0);
    end else begin
      // Pins now show the state of the previous cycle.
      m     = n - 1;
      idx   = (m / 8) % 4;
      off   = m % 8;
      upper = cur[19:4] >> (4 * idx);
      if (off < 2) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
      end else begin
        exp_an  = ~(4'(1) << idx);
        exp_seg = (lz_last && idx != 0 && upper == 0) ? 7'h7F : ~glyph_tab[upper[3:0]];
        exp_dp  = ~cur[idx];
      end
      check("an", n, 32'(an), 32'(exp_an));
      check("seg", n, 32'(seg), 32'(exp_seg));
      check("dp", n, 32'(dp), 32'(exp_dp));
      check("frame_done", n, 32'(frame_done), 32'((n % 32) == 0));
      if (n % 32 == 0) begin
        if (exp_q.size() == 0) begin
          check("frame_queue_empty", n, 32'(exp_q.size()), 32'h1);
        end else begin
          cur = exp_q.pop_front();
        end
      end
    end
    rst_last = RST;
    lz_last  = lz_blank;
  end

endmodule
